// File: rtl/lc3_ctrl.sv
// LC3 instruction-sequencing controller: FETCH/DECODE/EXECUTE/WRITEBACK plus data-memory wait states.
// Optional memory-wait abort is compiled in with LC3_CTRL_TIMEOUT_EN.
module lc3_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_dout,
  input  logic [2:0]  psr_nzp,
  input  logic        dmem_ready,
  output logic [3:0]  state,
  output logic [15:0] ir,
  output logic        br_taken,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        en_decode,
  output logic        en_execute,
  output logic        en_writeback,
  output logic        illegal,
  output logic        timeout
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_EXECUTE   = 4'd2;
  localparam logic [3:0] S_WRITEBACK = 4'd3;
  localparam logic [3:0] S_MEM_IND   = 4'd7;
  localparam logic [3:0] S_MEM_READ  = 4'd8;
  localparam logic [3:0] S_MEM_WRITE = 4'd9;

  logic [3:0] state_nxt;
  logic       br_nxt;
  logic       ill_set;
  logic       mem_state;

  assign en_decode    = (state == S_DECODE);
  assign en_execute   = (state == S_EXECUTE);
  assign en_writeback = (state == S_WRITEBACK);
  assign mem_rd       = (state == S_MEM_IND) || (state == S_MEM_READ);
  assign mem_wr       = (state == S_MEM_WRITE);
  assign mem_state    = mem_rd || mem_wr;

`ifdef LC3_CTRL_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              to_set;
`endif

  always_comb begin
    state_nxt = S_FETCH;
    br_nxt    = 1'b0;
    ill_set   = 1'b0;
    case (state)
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXECUTE;
      S_EXECUTE: begin
        case (ir[15:12])
          4'b0001, 4'b0101, 4'b1001, 4'b1110: state_nxt = S_WRITEBACK;
          4'b0010, 4'b0110:                   state_nxt = S_MEM_READ;
          4'b1010, 4'b1011:                   state_nxt = S_MEM_IND;
          4'b0011, 4'b0111:                   state_nxt = S_MEM_WRITE;
          4'b0000: br_nxt = |(ir[11:9] & psr_nzp);
          4'b1100: br_nxt = 1'b1;
          default: ill_set = 1'b1;
        endcase
      end
      // LDI and STI differ only in ir[12]
      S_MEM_IND:   state_nxt = dmem_ready ? (ir[12] ? S_MEM_WRITE : S_MEM_READ) : S_MEM_IND;
      S_MEM_READ:  state_nxt = dmem_ready ? S_WRITEBACK : S_MEM_READ;
      S_MEM_WRITE: state_nxt = dmem_ready ? S_FETCH : S_MEM_WRITE;
      S_WRITEBACK: state_nxt = S_FETCH;
      default:     state_nxt = S_FETCH;
    endcase
`ifdef LC3_CTRL_TIMEOUT_EN
    to_set = 1'b0;
    if (mem_state && !dmem_ready && (wait_cnt == WAIT_W'(TIMEOUT - 1))) begin
      state_nxt = S_FETCH;
      to_set    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_FETCH;
      ir       <= 16'h0000;
      br_taken <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_nxt;
      br_taken <= br_nxt;
      if (state == S_DECODE) ir <= instr_dout;
      if (ill_set) illegal <= 1'b1;
    end
  end

`ifdef LC3_CTRL_TIMEOUT_EN
  // Counter restarts whenever the state changes, so each memory access gets its own budget
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      if (state_nxt != state) wait_cnt <= '0;
      else if (mem_state)     wait_cnt <= wait_cnt + WAIT_W'(1);
      if (to_set) timeout <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

endmodule
